// File: rtl/exception_ctrl.sv
// Exception controller: accepts pipeline exceptions, latches EPC/cause, flushes and
// redirects to the handler, then returns to EPC on eret. All outputs are registered.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_inst,
    input  logic        exc_aluctrl,
    input  logic        exc_ovf,
    input  logic [31:0] pc_plus4,
    input  logic        eret,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [31:0] cause,
    output logic        exl,
    output logic [7:0]  exc_count
);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StHandler,
        StReturn
    } state_e;

    state_e      r_state;
    logic [31:0] r_epc;
    logic [31:0] r_cause;
    logic [7:0]  r_count;
    logic        r_flush;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_exl;

    logic        w_exc_any;
    logic [2:0]  w_exc_vec;

    assign w_exc_any = exc_inst | exc_aluctrl | exc_ovf;
    assign w_exc_vec = {exc_ovf, exc_aluctrl, exc_inst};

    // Outputs are loaded alongside the state so they always match the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_epc         <= 32'hFFFF_FFFF;
            r_cause       <= 32'd0;
            r_count       <= 8'd0;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_exl         <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_exc_any) begin
                        r_state       <= StFlush;
                        r_epc         <= pc_plus4 - 32'd4;
                        r_cause       <= {28'd0, r_cause[3], w_exc_vec};
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'd1;
                        end
                        r_flush       <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= HANDLER_ADDR;
                        r_exl         <= 1'b1;
                    end
                end
                StFlush: begin
                    r_state       <= StHandler;
                    r_flush       <= 1'b0;
                    r_redirect    <= 1'b0;
                    r_redirect_pc <= 32'd0;
                    r_exl         <= 1'b1;
                end
                StHandler: begin
                    // A fault while servicing only marks the sticky double-fault bit.
                    if (w_exc_any) begin
                        r_cause[3] <= 1'b1;
                    end
                    if (eret) begin
                        r_state       <= StReturn;
                        r_flush       <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= r_epc;
                    end
                end
                StReturn: begin
                    r_state       <= StIdle;
                    r_flush       <= 1'b0;
                    r_redirect    <= 1'b0;
                    r_redirect_pc <= 32'd0;
                    r_exl         <= 1'b0;
                end
                default: begin
                    r_state       <= StIdle;
                    r_flush       <= 1'b0;
                    r_redirect    <= 1'b0;
                    r_redirect_pc <= 32'd0;
                    r_exl         <= 1'b0;
                end
            endcase
        end
    end

    assign flush       = r_flush;
    assign pc_redirect = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign epc         = r_epc;
    assign cause       = r_cause;
    assign exl         = r_exl;
    assign exc_count   = r_count;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus random traffic,
// compared against a behavioural model of the exception-servicing sequence.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_inst;
    logic        exc_aluctrl;
    logic        exc_ovf;
    logic [31:0] pc_plus4;
    logic        eret;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        exl;
    logic [7:0]  exc_count;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = running, 1 = flushing into handler, 2 = in handler, 3 = returning.
    int          m_phase;
    logic [31:0] m_epc;
    logic [31:0] m_cause;
    int          m_count;

    exception_ctrl #(.HANDLER_ADDR(32'h0000_0180)) dut (
        .clk         (clk),
        .rst         (rst),
        .exc_inst    (exc_inst),
        .exc_aluctrl (exc_aluctrl),
        .exc_ovf     (exc_ovf),
        .pc_plus4    (pc_plus4),
        .eret        (eret),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .epc         (epc),
        .cause       (cause),
        .exl         (exl),
        .exc_count   (exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge(input bit r, input bit [2:0] e, input bit [31:0] p,
                                       input bit er);
        if (r) begin
            m_phase = 0;
            m_epc   = 32'hFFFF_FFFF;
            m_cause = 32'd0;
            m_count = 0;
        end else if (m_phase == 0) begin
            if (e != 3'b000) begin
                m_phase = 1;
                m_epc   = p - 32'd4;
                m_cause = {28'd0, m_cause[3], e};
                m_count = (m_count < 255) ? m_count + 1 : 255;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (e != 3'b000) m_cause[3] = 1'b1;
            if (er) m_phase = 3;
        end else begin
            m_phase = 0;
        end
    endfunction

    // One clock: drive inputs, advance model at the edge, compare all outputs 1ns later.
    task automatic cyc(input string tag, input bit r, input bit [2:0] e, input bit [31:0] p,
                       input bit er);
        logic [31:0] exp_pc;
        rst         = r;
        exc_ovf     = e[2];
        exc_aluctrl = e[1];
        exc_inst    = e[0];
        pc_plus4    = p;
        eret        = er;
        @(posedge clk);
        model_edge(r, e, p, er);
        #1;
        exp_pc = (m_phase == 1) ? 32'h180 : (m_phase == 3) ? m_epc : 32'd0;
        chk({tag, " flush"}, {31'd0, flush}, {31'd0, (m_phase == 1 || m_phase == 3)});
        chk({tag, " pc_redirect"}, {31'd0, pc_redirect},
            {31'd0, (m_phase == 1 || m_phase == 3)});
        chk({tag, " redirect_pc"}, redirect_pc, exp_pc);
        chk({tag, " exl"}, {31'd0, exl}, {31'd0, (m_phase != 0)});
        chk({tag, " epc"}, epc, m_epc);
        chk({tag, " cause"}, cause, m_cause);
        chk({tag, " exc_count"}, {24'd0, exc_count}, m_count[31:0]);
    endtask

    initial begin
        m_phase = 0;
        m_epc   = 32'hFFFF_FFFF;
        m_cause = 32'd0;
        m_count = 0;

        cyc("reset0", 1'b1, 3'b000, 32'd0, 1'b0);
        cyc("reset1", 1'b1, 3'b111, 32'h1234, 1'b1);
        chk("reset epc", epc, 32'hFFFF_FFFF);
        chk("reset flush", {31'd0, flush}, 32'd0);

        // Overflow accept, then double-fault in handler, then eret.
        cyc("ovf_accept", 1'b0, 3'b100, 32'h0040_0010, 1'b0);
        chk("s35 redirect_pc", redirect_pc, 32'h180);
        chk("s35 epc", epc, 32'h0040_000C);
        chk("s35 cause", cause, 32'h4);
        chk("s35 count", {24'd0, exc_count}, 32'd1);
        cyc("to_handler", 1'b0, 3'b000, 32'h0, 1'b0);
        chk("s35 exl", {31'd0, exl}, 32'd1);
        cyc("dbl_fault", 1'b0, 3'b010, 32'h0000_9000, 1'b0);
        chk("s38 cause", cause, 32'hC);
        chk("s38 epc", epc, 32'h0040_000C);
        cyc("eret", 1'b0, 3'b000, 32'h0, 1'b1);
        chk("s37 redirect_pc", redirect_pc, 32'h0040_000C);
        cyc("ret_idle", 1'b0, 3'b000, 32'h0, 1'b0);
        chk("s37 exl", {31'd0, exl}, 32'd0);
        cyc("idle_eret", 1'b0, 3'b000, 32'h0, 1'b1);

        // New accept with simultaneous eret keeps the double-fault bit.
        cyc("accept2", 1'b0, 3'b100, 32'h0000_2000, 1'b1);
        chk("s38 sticky", cause, 32'hC);
        cyc("flush_exc", 1'b0, 3'b111, 32'h0, 1'b1);
        cyc("handler2", 1'b0, 3'b000, 32'h0, 1'b0);

        // Reset in handler abandons the exception.
        cyc("rst_handler", 1'b1, 3'b000, 32'h0, 1'b0);
        chk("s40 epc", epc, 32'hFFFF_FFFF);
        chk("s40 pc_redirect", {31'd0, pc_redirect}, 32'd0);
        cyc("s40 idle_eret", 1'b0, 3'b000, 32'h0, 1'b1);

        // Two sources at once with pc_plus4 wrapping below zero.
        cyc("two_src", 1'b0, 3'b101, 32'h0, 1'b0);
        chk("s36 cause", cause, 32'h5);
        chk("s36 epc", epc, 32'hFFFF_FFFC);
        cyc("two_flush", 1'b0, 3'b000, 32'h0, 1'b0);
        cyc("two_eret", 1'b0, 3'b000, 32'h0, 1'b1);
        cyc("two_ret", 1'b0, 3'b000, 32'h0, 1'b0);

        // Saturation of the accept counter.
        cyc("sat_reset", 1'b1, 3'b000, 32'h0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            cyc("sat_acc", 1'b0, 3'b001, 32'h100 + 32'(i * 4), 1'b0);
            cyc("sat_fl", 1'b0, 3'b000, 32'h0, 1'b0);
            cyc("sat_er", 1'b0, 3'b000, 32'h0, 1'b1);
            cyc("sat_rt", 1'b0, 3'b000, 32'h0, 1'b0);
        end
        chk("s39 count", {24'd0, exc_count}, 32'hFF);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit [2:0]    e;
            bit          er;
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            er = ($urandom_range(0, 2) == 0);
            cyc("rand", r, e, $urandom, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
